display_scan_demux: RTL and testbench

//   Time-multiplexed driver for the oven's 4-digit common-anode 7-segment display.

---
 rtl/disp_pkg.sv | 24 ++
 rtl/display_scan_demux_if.sv | 27 ++
 rtl/bcd_to_7seg.sv | 18 +
 rtl/display_scan_demux.sv | 131 +++++++++++++
 tb/tb_display_scan_demux.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment display path.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package disp_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h40,  // 0
    7'h79,  // 1
    7'h24,  // 2
    7'h30,  // 3
    7'h19,  // 4
    7'h12,  // 5
    7'h02,  // 6
    7'h78,  // 7
    7'h00,  // 8
    7'h10   // 9
  };

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/display_scan_demux_if.sv
// Bundle between the timer/control datapath (master) and the display scan driver (slave).
// The master supplies digits and display modes; the slave returns the pin-level drive.
interface display_scan_demux_if;
  import disp_pkg::*;

  logic [4*NUM_DIGITS-1:0] digits_bcd;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    enable;
  logic                    blink;
  logic                    lz_suppress;

  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_start;

  modport master (
    output digits_bcd, dp_mask, enable, blink, lz_suppress,
    input  seg_n, dp_n, an_n, frame_start
  );

  modport slave (
    input  digits_bcd, dp_mask, enable, blink, lz_suppress,
    output seg_n, dp_n, an_n, frame_start
  );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10..15 are not digits and produce an all-off pattern.
module bcd_to_7seg
  import disp_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_n_o
);

  // NOTE: assign a default first so every path through always_comb drives the output; otherwise a latch is inferred.
  always_comb begin
    seg_n_o = SEG_BLANK;
    if (code_i < 4'd10) begin
      seg_n_o = SEG_LUT[code_i];
    end
  end

endmodule

// File: rtl/display_scan_demux.sv
// Time-multiplexed scan driver for a 4-digit common-anode 7-segment display.
// Snapshots the digits once per frame and drives one anode per slot after a short all-off guard.
module display_scan_demux
  import disp_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_scan_demux_if.slave  disp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]           presc_q, presc_d;
  digit_idx_t              idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    load_pending_q, load_pending_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;

  logic [6:0]              seg_n_q, seg_n_d;
  logic                    dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic                    frame_start_q, frame_start_d;

  logic                    tick;
  logic                    capture;
  logic                    guard;
  logic                    lz_dark;
  logic                    dark;
  logic                    blank;
  logic [3:0]              cur_digit;
  logic [6:0]              dec_seg;

  assign tick      = (presc_q == PW'(SCAN_DIV - 1));
  // The first clock after reset loads a snapshot so the display never shows stale zeros for a whole frame.
  assign capture   = load_pending_q | (tick & (idx_q == 2'd3));
  assign cur_digit = snap_digits_q[{idx_q, 2'b00} +: 4];

  bcd_to_7seg u_dec (
    .code_i  (cur_digit),
    .seg_n_o (dec_seg)
  );

  // Scan counters, frame snapshot and blink phase.
  always_comb begin
    presc_d        = tick ? '0 : presc_q + 1'b1;
    idx_d          = tick ? idx_q + 1'b1 : idx_q;
    load_pending_d = 1'b0;
    snap_digits_d  = capture ? disp.digits_bcd : snap_digits_q;
    snap_dp_d      = capture ? disp.dp_mask : snap_dp_q;
    blink_cnt_d    = blink_cnt_q;
    blink_phase_d  = blink_phase_q;
    if (!disp.blink) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (capture) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
      end
    end
  end

  // Leading-zero blanking: a digit is dark only when it and every digit to its left are zero.
  always_comb begin
    lz_dark = 1'b0;
    if (disp.lz_suppress) begin
      case (idx_q)
        2'd3:    lz_dark = (snap_digits_q[15:12] == 4'd0);
        2'd2:    lz_dark = (snap_digits_q[15:8] == 8'd0);
        2'd1:    lz_dark = (snap_digits_q[15:4] == 12'd0);
        default: lz_dark = 1'b0;
      endcase
    end
  end

  // enable and blink act on the live inputs so going dark takes effect on the next clock.
  assign guard = (presc_q < PW'(BLANK_CYCLES));
  assign dark  = ~disp.enable | (disp.blink & blink_phase_q) | lz_dark;
  assign blank = guard | dark;

  always_comb begin
    an_n_d        = blank ? {NUM_DIGITS{1'b1}} : ~(4'b0001 << idx_q);
    seg_n_d       = blank ? SEG_BLANK : dec_seg;
    dp_n_d        = blank ? 1'b1 : ~snap_dp_q[idx_q];
    frame_start_d = capture;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      idx_q          <= '0;
      snap_digits_q  <= '0;
      snap_dp_q      <= '0;
      load_pending_q <= 1'b1;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      seg_n_q        <= SEG_BLANK;
      dp_n_q         <= 1'b1;
      an_n_q         <= {NUM_DIGITS{1'b1}};
      frame_start_q  <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      snap_digits_q  <= snap_digits_d;
      snap_dp_q      <= snap_dp_d;
      load_pending_q <= load_pending_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      seg_n_q        <= seg_n_d;
      dp_n_q         <= dp_n_d;
      an_n_q         <= an_n_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign disp.seg_n       = seg_n_q;
  assign disp.dp_n        = dp_n_q;
  assign disp.an_n        = an_n_q;
  assign disp.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_demux.sv
// Self-checking bench for display_scan_demux: directed scenarios plus randomized inputs,
// every cycle compared against a slot-arithmetic reference model.
module tb_display_scan_demux;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FRAME = 4 * SD;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  logic auto_chk = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  display_scan_demux_if bus ();

  display_scan_demux #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .disp  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Active-low pattern for a 4-bit code, from the lit segment sets of each numeral.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] on;
    case (d)
      4'd0: on = 7'h3F;  4'd1: on = 7'h06;  4'd2: on = 7'h5B;  4'd3: on = 7'h4F;
      4'd4: on = 7'h66;  4'd5: on = 7'h6D;  4'd6: on = 7'h7D;  4'd7: on = 7'h07;
      4'd8: on = 7'h7F;  4'd9: on = 7'h6F;  default: on = 7'h00;
    endcase
    return ~on;
  endfunction

  // k = clock edges since reset release; the scan position is pure arithmetic on k.
  function automatic logic is_capture(input int k);
    return (k == 0) || ((k % FRAME) == FRAME - 1);
  endfunction

  function automatic out_t predict(input int k, input logic [15:0] snap, input logic [3:0] dpm, input int n);
    out_t o;
    int   p      = k % SD;
    int   i      = (k / SD) % 4;
    logic phase  = ((n / BF) % 2) == 1;
    logic zeros  = 1'b1;
    logic dark;
    for (int j = i; j < 4; j++) if (snap[j*4 +: 4] != 4'd0) zeros = 1'b0;
    dark = !bus.enable || (bus.blink && phase) || (bus.lz_suppress && i != 0 && zeros);
    if (p < BC || dark) begin
      o.seg = 7'h7F; o.dp = 1'b1; o.an = 4'hF;
    end else begin
      o.seg = seg_of(snap[i*4 +: 4]);
      o.dp  = ~dpm[i];
      o.an  = ~(4'b0001 << i);
    end
    return o;
  endfunction

  int          m_k;
  logic [15:0] m_snap;
  logic [3:0]  m_dp;
  int          m_n;
  out_t        e_out;
  logic        e_fs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k    <= 0;
      m_snap <= '0;
      m_dp   <= '0;
      m_n    <= 0;
      e_out  <= '{seg: 7'h7F, dp: 1'b1, an: 4'hF};
      e_fs   <= 1'b0;
    end else begin
      e_out <= predict(m_k, m_snap, m_dp, m_n);
      e_fs  <= is_capture(m_k);
      m_k   <= m_k + 1;
      if (is_capture(m_k)) begin
        m_snap <= bus.digits_bcd;
        m_dp   <= bus.dp_mask;
      end
      m_n <= !bus.blink ? 0 : (is_capture(m_k) ? m_n + 1 : m_n);
    end
  end

  always @(negedge clk) begin
    if (auto_chk) begin
      check("seg_n", bus.seg_n, e_out.seg);
      check("dp_n", bus.dp_n, e_out.dp);
      check("an_n", bus.an_n, e_out.an);
      check("frame_start", bus.frame_start, e_fs);
    end
  end

  task automatic wait_an(input string tag, input logic [3:0] val, input int budget);
    int c = 0;
    do begin @(negedge clk); c++; end while (bus.an_n !== val && c < budget);
    check(tag, bus.an_n, val);
  endtask

  task automatic wait_fs(input string tag);
    int c = 0;
    do begin @(negedge clk); c++; end while (bus.frame_start !== 1'b1 && c < FRAME + 8);
    check(tag, bus.frame_start, 1'b1);
  endtask

  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_an"}, bus.an_n, 4'hF);
    check({tag, "_seg"}, bus.seg_n, 7'h7F);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check({tag, "_fs"}, bus.frame_start, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  lane_an [4];
    logic [6:0]  lane_seg [4];
    logic        lit;
    logic [15:0] rd;
    int          bad, seen0;

    lane_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    lane_seg = '{7'h19, 7'h30, 7'h24, 7'h79};

    rst_n = 1'b0;
    bus.digits_bcd = 16'h1234; bus.dp_mask = 4'b0000;
    bus.enable = 1'b1; bus.blink = 1'b0; bus.lz_suppress = 1'b0;
    repeat (3) @(negedge clk);
    auto_chk = 1'b1;
    check("rst_an", bus.an_n, 4'hF);
    check("rst_seg", bus.seg_n, 7'h7F);
    check("rst_dp", bus.dp_n, 1'b1);
    check("rst_fs", bus.frame_start, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_fs", bus.frame_start, 1'b1);

    // Scan order and guard interval over one full frame of "1234".
    wait_fs("s2_fs");
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < SD; c++) begin
        @(negedge clk);
        if (c < BC) check("s2_guard", bus.an_n, 4'hF);
        else        check("s2_anode", bus.an_n, lane_an[s]);
        if (c == SD - 1) check("s2_seg", bus.seg_n, lane_seg[s]);
      end
    end

    // Mid-frame input change stays invisible until the next frame.
    wait_an("s3_slot1", 4'b1101, FRAME);
    bus.digits_bcd = 16'h5678;
    @(negedge clk);
    check("s3_still3", bus.seg_n, 7'h30);
    wait_an("s3_slot2", 4'b1011, FRAME);
    check("s3_still2", bus.seg_n, 7'h24);
    wait_an("s3_slot3", 4'b0111, FRAME);
    check("s3_still1", bus.seg_n, 7'h79);
    wait_an("s3_slot0", 4'b1110, FRAME);
    check("s3_new8", bus.seg_n, 7'h00);

    // Asynchronous reset while digit2 is lit.
    wait_an("s1_slot2", 4'b1011, FRAME);
    mid_reset("s1_rst");

    // Leading-zero suppression.
    bus.lz_suppress = 1'b1;
    bus.digits_bcd  = 16'h0045;
    wait_fs("s4_fs");
    bad = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      if (bus.an_n[3] == 1'b0 || bus.an_n[2] == 1'b0) bad++;
    end
    check("s4_upper_dark", bad, 0);
    wait_an("s4_slot1", 4'b1101, FRAME);
    check("s4_seg4", bus.seg_n, 7'h19);
    wait_an("s4_slot0", 4'b1110, FRAME);
    check("s4_seg5", bus.seg_n, 7'h12);
    bus.digits_bcd = 16'h0000;
    wait_fs("s4_fs0");
    bad = 0; seen0 = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (bus.an_n != 4'hF && bus.an_n != 4'b1110) bad++;
      if (bus.an_n == 4'b1110) begin
        seen0++;
        check("s4_seg0", bus.seg_n, 7'h40);
      end
    end
    check("s4_only_d0", bad, 0);
    check("s4_d0_lit", seen0, SD - BC);

    // Blink: two frames lit, two dark, starting with the frame after blink rises.
    bus.lz_suppress = 1'b0;
    bus.digits_bcd  = 16'h1234;
    wait_fs("s5_fsA");
    repeat (10) @(negedge clk);
    bus.blink = 1'b1;
    wait_fs("s5_fsB");
    for (int f = 0; f < 6; f++) begin
      lit = 1'b0;
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        if (bus.an_n != 4'hF) lit = 1'b1;
      end
      check("s5_frame_lit", lit, (f % 4) == 0 || (f % 4) == 3);
    end
    repeat (12) @(negedge clk);
    check("s5_dark", bus.an_n, 4'hF);
    bus.blink = 1'b0;
    wait_an("s5_release_lit", 4'b1011, 2 * SD);

    // Non-decimal codes blank segments but keep the anode; decimal point per slot.
    bus.digits_bcd = 16'h00AF;
    bus.dp_mask    = 4'b0010;
    wait_fs("s6_fs");
    wait_an("s6_slot0", 4'b1110, FRAME);
    check("s6_seg0", bus.seg_n, 7'h7F);
    check("s6_dp0", bus.dp_n, 1'b1);
    wait_an("s6_slot1", 4'b1101, FRAME);
    check("s6_seg1", bus.seg_n, 7'h7F);
    check("s6_dp1", bus.dp_n, 1'b0);
    bus.enable = 1'b0;
    @(negedge clk);
    check("s6_disable", bus.an_n, 4'hF);
    repeat (5) @(negedge clk);
    bus.enable = 1'b1;

    // Randomized traffic, including occasional mid-slot resets.
    for (int r = 0; r < 60; r++) begin
      repeat ($urandom_range(3, 70)) @(negedge clk);
      rd = 16'($urandom);
      if ($urandom_range(0, 1) == 1) rd[15:8] = 8'h00;
      if ($urandom_range(0, 3) == 0) rd[7:4] = 4'h0;
      bus.digits_bcd  = rd;
      bus.dp_mask     = 4'($urandom);
      bus.enable      = ($urandom_range(0, 7) != 0);
      bus.blink       = ($urandom_range(0, 3) == 0);
      bus.lz_suppress = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 19) == 0) mid_reset("rand_rst");
    end
    repeat (FRAME) @(negedge clk);

    auto_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
